// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two small result FIFOs (ALU, LSB) drained one entry per
// cycle by a round-robin grant into a registered broadcast.
module cdb_arbiter #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_val,
    output logic              alu_ready,
    input  logic              lsb_valid,
    input  logic [TAG_W-1:0]  lsb_tag,
    input  logic [DATA_W-1:0] lsb_val,
    output logic              lsb_ready,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_val,
    output logic              cdb_src
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Index 0 is the ALU source, index 1 the LSB source.
    logic [TAG_W-1:0]  tag_mem_r [2][DEPTH];
    logic [DATA_W-1:0] val_mem_r [2][DEPTH];
    logic [PTR_W-1:0]  wptr_r [2];
    logic [PTR_W-1:0]  rptr_r [2];
    logic [CNT_W-1:0]  cnt_r [2];
    logic              last_grant_r;
    logic              cdb_valid_r;
    logic [TAG_W-1:0]  cdb_tag_r;
    logic [DATA_W-1:0] cdb_val_r;
    logic              cdb_src_r;

    logic [1:0]        in_valid_s;
    logic [TAG_W-1:0]  in_tag_s [2];
    logic [DATA_W-1:0] in_val_s [2];
    logic [1:0]        ready_s;
    logic [1:0]        nonempty_s;
    logic [1:0]        push_s;
    logic [1:0]        pop_s;
    logic              grant_valid_s;
    logic              grant_src_s;
    logic [TAG_W-1:0]  head_tag_s;
    logic [DATA_W-1:0] head_val_s;

    assign in_valid_s  = {lsb_valid, alu_valid};
    assign in_tag_s[0] = alu_tag;
    assign in_tag_s[1] = lsb_tag;
    assign in_val_s[0] = alu_val;
    assign in_val_s[1] = lsb_val;

    assign alu_ready = ready_s[0];
    assign lsb_ready = ready_s[1];
    assign cdb_valid = cdb_valid_r;
    assign cdb_tag   = cdb_tag_r;
    assign cdb_val   = cdb_val_r;
    assign cdb_src   = cdb_src_r;

    // Per-source occupancy flags and enqueue qualification; ready never looks at valid.
    always_comb begin
        ready_s    = 2'b00;
        nonempty_s = 2'b00;
        push_s     = 2'b00;
        for (int i = 0; i < 2; i++) begin
            ready_s[i]    = (cnt_r[i] < DEPTH_C);
            nonempty_s[i] = (cnt_r[i] != {CNT_W{1'b0}});
            push_s[i]     = rdy_in & ~clear & in_valid_s[i] & ready_s[i]
                          & (in_tag_s[i] != {TAG_W{1'b0}});
        end
    end

    // Round-robin grant over the heads as they stand before this edge's enqueue.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_src_s   = 1'b0;
        case (nonempty_s)
            2'b11: begin
                grant_valid_s = 1'b1;
                grant_src_s   = ~last_grant_r;
            end
            2'b01: begin
                grant_valid_s = 1'b1;
                grant_src_s   = 1'b0;
            end
            2'b10: begin
                grant_valid_s = 1'b1;
                grant_src_s   = 1'b1;
            end
            default: begin
                grant_valid_s = 1'b0;
                grant_src_s   = 1'b0;
            end
        endcase
        pop_s[0]   = rdy_in & ~clear & grant_valid_s & ~grant_src_s;
        pop_s[1]   = rdy_in & ~clear & grant_valid_s & grant_src_s;
        head_tag_s = tag_mem_r[grant_src_s][rptr_r[grant_src_s]];
        head_val_s = val_mem_r[grant_src_s][rptr_r[grant_src_s]];
    end

    // FIFO storage write; contents need no reset since counts gate every read.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < 2; i++) begin
            if (push_s[i]) begin
                tag_mem_r[i][wptr_r[i]] <= in_tag_s[i];
                val_mem_r[i][wptr_r[i]] <= in_val_s[i];
            end
        end
    end

    // Pointers, counts, round-robin state and the registered broadcast.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 2; i++) begin
                wptr_r[i] <= {PTR_W{1'b0}};
                rptr_r[i] <= {PTR_W{1'b0}};
                cnt_r[i]  <= {CNT_W{1'b0}};
            end
            last_grant_r <= 1'b1;
            cdb_valid_r  <= 1'b0;
            cdb_tag_r    <= {TAG_W{1'b0}};
            cdb_val_r    <= {DATA_W{1'b0}};
            cdb_src_r    <= 1'b0;
        end else if (rdy_in) begin
            if (clear) begin
                for (int i = 0; i < 2; i++) begin
                    wptr_r[i] <= {PTR_W{1'b0}};
                    rptr_r[i] <= {PTR_W{1'b0}};
                    cnt_r[i]  <= {CNT_W{1'b0}};
                end
                cdb_valid_r <= 1'b0;
                cdb_tag_r   <= {TAG_W{1'b0}};
                cdb_val_r   <= {DATA_W{1'b0}};
                cdb_src_r   <= 1'b0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (push_s[i]) begin
                        wptr_r[i] <= wptr_r[i] + PTR_W'(1);
                    end
                    if (pop_s[i]) begin
                        rptr_r[i] <= rptr_r[i] + PTR_W'(1);
                    end
                    case ({push_s[i], pop_s[i]})
                        2'b10:   cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                        2'b01:   cnt_r[i] <= cnt_r[i] - CNT_W'(1);
                        default: cnt_r[i] <= cnt_r[i];
                    endcase
                end
                if (grant_valid_s) begin
                    cdb_valid_r  <= 1'b1;
                    cdb_tag_r    <= head_tag_s;
                    cdb_val_r    <= head_val_s;
                    cdb_src_r    <= grant_src_s;
                    last_grant_r <= grant_src_s;
                end else begin
                    cdb_valid_r <= 1'b0;
                    cdb_tag_r   <= {TAG_W{1'b0}};
                    cdb_val_r   <= {DATA_W{1'b0}};
                    cdb_src_r   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, round-robin fairness, back-pressure,
// clear, rdy_in freeze and asynchronous reset, with hand-computed expectations.
module tb_cdb_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear;
    logic        alu_valid, lsb_valid, alu_ready, lsb_ready;
    logic        cdb_valid, cdb_src;
    logic [4:0]  alu_tag, lsb_tag, cdb_tag;
    logic [31:0] alu_val, lsb_val, cdb_val;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk_in = ~clk_in;

    cdb_arbiter #(.TAG_W(5), .DATA_W(32), .DEPTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_val(alu_val), .alu_ready(alu_ready),
        .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_val(lsb_val), .lsb_ready(lsb_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_src(cdb_src)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle;
        clear     = 1'b0;
        alu_valid = 1'b0;
        alu_tag   = 5'd0;
        alu_val   = 32'd0;
        lsb_valid = 1'b0;
        lsb_tag   = 5'd0;
        lsb_val   = 32'd0;
    endtask

    task automatic do_reset;
        rst_in = 1'b1;
        rdy_in = 1'b1;
        idle();
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic expect_cdb(input string tag, input logic v, input logic [4:0] t,
                              input logic [31:0] d, input logic s);
        check_eq({tag, "_valid"}, cdb_valid, v);
        check_eq({tag, "_tag"}, cdb_tag, t);
        check_eq({tag, "_val"}, cdb_val, d);
        check_eq({tag, "_src"}, cdb_src, s);
    endtask

    // Producers must never present a result into a full FIFO.
    always @(negedge clk_in) begin
        if (rdy_in && !rst_in && alu_valid) check_eq("proto_alu_ready", alu_ready, 1'b1);
        if (rdy_in && !rst_in && lsb_valid) check_eq("proto_lsb_ready", lsb_ready, 1'b1);
    end

    logic [5:0] bcast_q [$];
    logic [5:0] flood_exp [14];
    logic       saw_lsb_full;
    int         a_next, l_next;
    logic       a_go, l_go;

    initial begin
        // Reset state and single-result latency.
        do_reset();
        expect_cdb("rst", 1'b0, 5'd0, 32'd0, 1'b0);
        check_eq("rst_alu_ready", alu_ready, 1'b1);
        check_eq("rst_lsb_ready", lsb_ready, 1'b1);
        alu_valid = 1'b1; alu_tag = 5'd3; alu_val = 32'h11;
        tick();
        idle();
        check_eq("lat_e1_valid", cdb_valid, 1'b0);
        tick();
        expect_cdb("lat_e2", 1'b1, 5'd3, 32'h11, 1'b0);
        tick();
        check_eq("lat_e3_valid", cdb_valid, 1'b0);

        // Simultaneous results: ALU wins first tie after reset, then alternation.
        do_reset();
        alu_valid = 1'b1; alu_tag = 5'd1; alu_val = 32'hA1;
        lsb_valid = 1'b1; lsb_tag = 5'd2; lsb_val = 32'hB2;
        tick();
        idle();
        check_eq("rr_e1_valid", cdb_valid, 1'b0);
        tick();
        expect_cdb("rr_first", 1'b1, 5'd1, 32'hA1, 1'b0);
        tick();
        expect_cdb("rr_second", 1'b1, 5'd2, 32'hB2, 1'b1);
        tick();
        check_eq("rr_gap_valid", cdb_valid, 1'b0);
        alu_valid = 1'b1; alu_tag = 5'd4; alu_val = 32'hA4;
        lsb_valid = 1'b1; lsb_tag = 5'd5; lsb_val = 32'hB5;
        tick();
        idle();
        tick();
        expect_cdb("rr_third", 1'b1, 5'd4, 32'hA4, 1'b0);
        tick();
        expect_cdb("rr_fourth", 1'b1, 5'd5, 32'hB5, 1'b1);

        // Contention: LSB tags 1..6 against ALU tags 10..17; drive only when ready.
        do_reset();
        flood_exp = '{6'h0A, 6'h21, 6'h0B, 6'h22, 6'h0C, 6'h23, 6'h0D,
                      6'h24, 6'h0E, 6'h25, 6'h0F, 6'h26, 6'h10, 6'h11};
        a_next = 10;
        l_next = 1;
        saw_lsb_full = 1'b0;
        for (int c = 0; c < 20; c++) begin
            a_go = (a_next <= 17) && alu_ready;
            l_go = (l_next <= 6) && lsb_ready;
            alu_valid = a_go; alu_tag = 5'(a_next); alu_val = 32'(a_next) + 32'h100;
            lsb_valid = l_go; lsb_tag = 5'(l_next); lsb_val = 32'(l_next) + 32'h200;
            tick();
            if (a_go) a_next++;
            if (l_go) l_next++;
            if (!lsb_ready) saw_lsb_full = 1'b1;
            if (cdb_valid) bcast_q.push_back({cdb_src, cdb_tag});
        end
        idle();
        check_eq("flood_lsb_backpressure", saw_lsb_full, 1'b1);
        check_eq("flood_count", bcast_q.size(), 14);
        for (int i = 0; i < 14; i++) begin
            check_eq($sformatf("flood_bcast%0d", i),
                     (i < bcast_q.size()) ? bcast_q[i] : 6'h3F, flood_exp[i]);
        end

        // Clear with entries pending; last grant (ALU) must survive the flush.
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1; alu_tag = 5'(7 + k); alu_val = 32'(32'h70 + k);
            tick();
        end
        expect_cdb("clr_pre", 1'b1, 5'd8, 32'h71, 1'b0);
        clear = 1'b1;
        alu_valid = 1'b1; alu_tag = 5'd20; alu_val = 32'h2020;
        tick();
        idle();
        expect_cdb("clr_edge", 1'b0, 5'd0, 32'd0, 1'b0);
        check_eq("clr_alu_ready", alu_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("clr_idle%0d_valid", k), cdb_valid, 1'b0);
        end
        alu_valid = 1'b1; alu_tag = 5'd21; alu_val = 32'h21;
        lsb_valid = 1'b1; lsb_tag = 5'd22; lsb_val = 32'h22;
        tick();
        idle();
        tick();
        expect_cdb("clr_lg_first", 1'b1, 5'd22, 32'h22, 1'b1);
        tick();
        expect_cdb("clr_lg_second", 1'b1, 5'd21, 32'h21, 1'b0);

        // Freeze mid-stream: clear and enqueue while rdy_in=0 are ignored.
        for (int k = 1; k <= 3; k++) begin
            alu_valid = 1'b1; alu_tag = 5'(k); alu_val = 32'(32'h100 + k);
            tick();
        end
        idle();
        expect_cdb("frz_pre", 1'b1, 5'd2, 32'h102, 1'b0);
        rdy_in = 1'b0;
        clear = 1'b1;
        alu_valid = 1'b1; alu_tag = 5'd30; alu_val = 32'h3030;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_cdb($sformatf("frz%0d", k), 1'b1, 5'd2, 32'h102, 1'b0);
        end
        idle();
        rdy_in = 1'b1;
        tick();
        expect_cdb("frz_resume", 1'b1, 5'd3, 32'h103, 1'b0);
        tick();
        check_eq("frz_after_valid", cdb_valid, 1'b0);

        // Asynchronous reset while a broadcast is on the bus.
        alu_valid = 1'b1; alu_tag = 5'd5; alu_val = 32'h55;
        tick();
        alu_tag = 5'd6; alu_val = 32'h66;
        tick();
        idle();
        expect_cdb("arst_pre", 1'b1, 5'd5, 32'h55, 1'b0);
        #2 rst_in = 1'b1;
        #1;
        expect_cdb("arst_now", 1'b0, 5'd0, 32'd0, 1'b0);
        #1 rst_in = 1'b0;
        alu_valid = 1'b1; alu_tag = 5'd0; alu_val = 32'hDEAD;
        tick();
        idle();
        check_eq("arst_alu_ready", alu_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("arst_empty%0d_valid", k), cdb_valid, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
